mandel_sched: RTL and testbench

MANDEL_SCHED -- requirements
Module: mandel_sched

---
 rtl/mandel_sched.sv | 202 ++++++++++++++++++++
 tb/tb_mandel_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_sched.sv
// Frame scheduler for a pool of shared Mandelbrot iteration cores: walks the
// framebuffer in raster order, hands pixels to free cores and serialises results.
module mandel_sched #(
    parameter int CORES     = 4,
    parameter int FP_WIDTH  = 25,
    parameter int ITERW     = 8,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 180,
    parameter int ADDRW     = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic                      clk_sys,
    input  logic                      rst_sys,
    input  logic                      start,
    input  logic [FP_WIDTH-1:0]       x_start,
    input  logic [FP_WIDTH-1:0]       y_start,
    input  logic [FP_WIDTH-1:0]       step,
    output logic                      busy,
    output logic                      done,
    output logic [CORES-1:0]          core_start,
    output logic [CORES*FP_WIDTH-1:0] core_re,
    output logic [CORES*FP_WIDTH-1:0] core_im,
    input  logic [CORES-1:0]          core_done,
    input  logic [CORES*ITERW-1:0]    core_iter,
    output logic                      fb_we,
    output logic [ADDRW-1:0]          fb_addr,
    output logic [ITERW-1:0]          fb_data,
    input  logic                      fb_ready
);

    localparam int NPIX = FB_WIDTH * FB_HEIGHT;
    localparam int COLW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
    localparam int IDXW = (CORES > 1) ? $clog2(CORES) : 1;
    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(NPIX - 1);
    localparam logic [COLW-1:0]  LAST_COL  = COLW'(FB_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_DISPATCH,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t               state;
    logic [FP_WIDTH-1:0]  x_lat;
    logic [FP_WIDTH-1:0]  step_lat;
    logic [FP_WIDTH-1:0]  re;
    logic [FP_WIDTH-1:0]  im;
    logic [COLW-1:0]      col;
    logic [ADDRW-1:0]     pix_addr;
    logic [CORES-1:0]     occupied;
    logic [CORES-1:0]     pending;
    logic [IDXW-1:0]      wr_sel;

    logic [ADDRW-1:0]     tag    [CORES];
    logic [ITERW-1:0]     result [CORES];

    logic                 xfer;
    logic                 issue;
    logic                 free_any;
    logic                 pend_any;
    logic [IDXW-1:0]      free_sel;
    logic [IDXW-1:0]      pend_sel;
    logic [CORES-1:0]     free_vec;
    logic [CORES-1:0]     done_acc;
    logic [CORES-1:0]     pend_n;
    logic [CORES-1:0]     issue_vec;
    logic [ITERW-1:0]     pend_data;

    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latch).
    always_comb begin
        xfer     = fb_we && fb_ready;
        done_acc = core_done & occupied;
        free_vec = ~(occupied | pending);
        pend_n   = pending | done_acc;
        if (xfer) begin
            pend_n[wr_sel] = 1'b0;
        end
        free_any = 1'b0;
        free_sel = '0;
        pend_any = 1'b0;
        pend_sel = '0;
        // Scan downward so the lowest index is the one left standing.
        for (int i = CORES - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                free_any = 1'b1;
                free_sel = IDXW'(i);
            end
            if (pend_n[i]) begin
                pend_any = 1'b1;
                pend_sel = IDXW'(i);
            end
        end
        // A result arriving this cycle is not in result[] yet; bypass it.
        pend_data = done_acc[pend_sel] ? core_iter[pend_sel*ITERW +: ITERW] : result[pend_sel];
        issue     = (state == S_DISPATCH) && free_any;
        issue_vec = issue ? (CORES'(1) << free_sel) : '0;
    end

    // NOTE: tag/result storage carries no reset; occupied/pending say which entries are meaningful.
    always_ff @(posedge clk_sys) begin
        for (int i = 0; i < CORES; i++) begin
            if (done_acc[i]) begin
                result[i] <= core_iter[i*ITERW +: ITERW];
            end
        end
        if (issue) begin
            tag[free_sel] <= pix_addr;
        end
    end

    // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            core_start <= '0;
            core_re    <= '0;
            core_im    <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            occupied   <= '0;
            pending    <= '0;
            wr_sel     <= '0;
            x_lat      <= '0;
            step_lat   <= '0;
            re         <= '0;
            im         <= '0;
            col        <= '0;
            pix_addr   <= '0;
        end else begin
            core_start <= '0;
            done       <= 1'b0;
            occupied   <= (occupied & ~done_acc) | issue_vec;
            pending    <= pend_n;

            // A presented write stays frozen until the framebuffer takes it.
            if (!fb_we || xfer) begin
                fb_we <= pend_any;
                if (pend_any) begin
                    wr_sel  <= pend_sel;
                    fb_addr <= tag[pend_sel];
                    fb_data <= pend_data;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_INIT;
                        busy  <= 1'b1;
                    end
                end
                S_INIT: begin
                    x_lat    <= x_start;
                    step_lat <= step;
                    re       <= x_start;
                    im       <= y_start;
                    col      <= '0;
                    pix_addr <= '0;
                    state    <= S_DISPATCH;
                end
                S_DISPATCH: begin
                    if (free_any) begin
                        core_start[free_sel]                   <= 1'b1;
                        core_re[free_sel*FP_WIDTH +: FP_WIDTH] <= re;
                        core_im[free_sel*FP_WIDTH +: FP_WIDTH] <= im;
                        if (col != LAST_COL) begin
                            col <= col + 1'b1;
                            re  <= re + step_lat;
                        end else begin
                            col <= '0;
                            re  <= x_lat;
                            im  <= im + step_lat;
                        end
                        pix_addr <= pix_addr + 1'b1;
                        if (pix_addr == LAST_ADDR) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (occupied == '0 && pending == '0) begin
                        state <= S_FINISH;
                        done  <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mandel_sched.sv
// Directed bench for mandel_sched on a 4x2 frame with two behavioural cores;
// frame vectors come from a table, arbitration/stall/reset cases are hand sequences.
module tb_mandel_sched;

    localparam int CORES = 2;
    localparam int FPW   = 8;
    localparam int ITW   = 8;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int NPIX  = W * H;
    localparam int AW    = 3;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] stp;
        int         lat;
        int         rmode;
        bit         restart;
        logic [7:0] re5;
        logic [7:0] im5;
    } vec_t;

    logic                  clk_sys = 1'b0;
    logic                  rst_sys = 1'b1;
    logic                  start   = 1'b0;
    logic [FPW-1:0]        x_start = '0;
    logic [FPW-1:0]        y_start = '0;
    logic [FPW-1:0]        step    = '0;
    logic                  busy;
    logic                  done;
    logic [CORES-1:0]      core_start;
    logic [CORES*FPW-1:0]  core_re;
    logic [CORES*FPW-1:0]  core_im;
    logic [CORES-1:0]      core_done = '0;
    logic [CORES*ITW-1:0]  core_iter = '0;
    logic                  fb_we;
    logic [AW-1:0]         fb_addr;
    logic [ITW-1:0]        fb_data;
    logic                  fb_ready  = 1'b1;

    mandel_sched #(
        .CORES(CORES), .FP_WIDTH(FPW), .ITERW(ITW), .FB_WIDTH(W), .FB_HEIGHT(H)
    ) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .start(start),
        .x_start(x_start), .y_start(y_start), .step(step),
        .busy(busy), .done(done),
        .core_start(core_start), .core_re(core_re), .core_im(core_im),
        .core_done(core_done), .core_iter(core_iter),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready)
    );

    initial forever #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk_sys) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Frame configuration, written only by the stimulus process.
    logic [7:0] cur_x, cur_y, cur_step;
    logic [7:0] exp_data [NPIX];
    int         lat_cfg    = 3;
    int         ready_mode = 0;
    bit         auto_core  = 1'b1;
    int         clr_seq    = 0;
    int         man_seq    = 0;
    logic [CORES-1:0]     man_done = '0;
    logic [CORES*ITW-1:0] man_iter = '0;

    function automatic logic [7:0] model_re(input int a);
        logic [7:0] r = cur_x;
        for (int k = 0; k < a % W; k++) r = r + cur_step;
        return r;
    endfunction

    function automatic logic [7:0] model_im(input int a);
        logic [7:0] r = cur_y;
        for (int k = 0; k < a / W; k++) r = r + cur_step;
        return r;
    endfunction

    // Behavioural cores: answer re^im after lat_cfg cycles; framebuffer ready pattern.
    int         cnt [CORES];
    logic [7:0] it  [CORES];
    int         man_ack = 0;
    always @(negedge clk_sys) begin
        core_done = '0;
        for (int i = 0; i < CORES; i++) begin
            if (core_start[i] && auto_core) begin
                cnt[i] = lat_cfg;
                it[i]  = core_re[i*FPW +: FPW] ^ core_im[i*FPW +: FPW];
            end else if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    core_done[i]           = 1'b1;
                    core_iter[i*ITW +: ITW] = it[i];
                end
            end
        end
        if (man_seq != man_ack) begin
            core_done = man_done;
            core_iter = man_iter;
            man_ack   = man_seq;
        end
        fb_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ((cyc % 3) != 0) : 1'b0;
    end

    // Monitor, sampled just before each rising edge.
    int         issue_idx, nwr, ndone, first_cs_cyc;
    int         clr_ack = 0;
    int         wr_count [NPIX];
    int         wr_log_addr [16];
    int         wr_log_cyc  [16];
    int         tb_tag [CORES];
    bit [CORES-1:0] tb_busy;
    bit         prev_stall;
    logic [AW-1:0]  prev_addr;
    logic [ITW-1:0] prev_data;
    logic [7:0] cap_re5, cap_im5;

    always @(negedge clk_sys) begin
        #4;
        if (clr_seq != clr_ack) begin
            clr_ack = clr_seq;
            issue_idx = 0; nwr = 0; ndone = 0; first_cs_cyc = -1;
            tb_busy = '0; prev_stall = 1'b0;
            cap_re5 = 'x; cap_im5 = 'x;
            for (int a = 0; a < NPIX; a++) wr_count[a] = 0;
        end
        if (core_start != '0) begin
            check("one_start_per_cycle", 32'($countones(core_start)), 32'd1);
            for (int i = 0; i < CORES; i++) begin
                if (core_start[i]) begin
                    check("start_to_free_core", 32'(tb_busy[i]), 32'd0);
                    check("issue_in_frame", 32'(issue_idx < NPIX), 32'd1);
                    check("issue_re", 32'(core_re[i*FPW +: FPW]), 32'(model_re(issue_idx)));
                    check("issue_im", 32'(core_im[i*FPW +: FPW]), 32'(model_im(issue_idx)));
                    if (issue_idx == 5) begin
                        cap_re5 = core_re[i*FPW +: FPW];
                        cap_im5 = core_im[i*FPW +: FPW];
                    end
                    if (first_cs_cyc < 0) first_cs_cyc = cyc;
                    tb_busy[i] = 1'b1;
                    tb_tag[i]  = issue_idx;
                    issue_idx++;
                end
            end
        end
        if (fb_we && fb_ready && !rst_sys) begin
            check("wr_data", 32'(fb_data), 32'(exp_data[fb_addr]));
            wr_count[fb_addr]++;
            if (nwr < 16) begin
                wr_log_addr[nwr] = int'(fb_addr);
                wr_log_cyc[nwr]  = cyc;
            end
            nwr++;
            for (int i = 0; i < CORES; i++)
                if (tb_busy[i] && tb_tag[i] == int'(fb_addr)) tb_busy[i] = 1'b0;
        end
        if (prev_stall && !rst_sys) begin
            check("hold_we", 32'(fb_we), 32'd1);
            check("hold_addr", 32'(fb_addr), 32'(prev_addr));
            check("hold_data", 32'(fb_data), 32'(prev_data));
        end
        prev_stall = fb_we && !fb_ready && !rst_sys;
        prev_addr  = fb_addr;
        prev_data  = fb_data;
        if (done) ndone++;
    end

    task automatic setup(input logic [7:0] x, input logic [7:0] y, input logic [7:0] s,
                         input int lat, input int rmode);
        cur_x = x; cur_y = y; cur_step = s;
        lat_cfg = lat; ready_mode = rmode; auto_core = 1'b1;
        for (int a = 0; a < NPIX; a++) exp_data[a] = model_re(a) ^ model_im(a);
        clr_seq++;
        @(negedge clk_sys);
        x_start = x; y_start = y; step = s;
    endtask

    task automatic pulse_start(output int t0);
        @(negedge clk_sys);
        start = 1'b1;
        t0    = cyc;
        @(negedge clk_sys);
        start = 1'b0;
    endtask

    task automatic wait_frame(input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_sys);
            if (ndone > 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({nm, "_completes"}, 32'(ok), 32'd1);
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic frame_checks(input string nm);
        int once = 0;
        for (int a = 0; a < NPIX; a++) if (wr_count[a] == 1) once++;
        check({nm, "_writes"}, 32'(nwr), 32'(NPIX));
        check({nm, "_addr_once"}, 32'(once), 32'(NPIX));
        check({nm, "_done_pulses"}, 32'(ndone), 32'd1);
        check({nm, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic run_frame(input vec_t v, input string nm);
        int t0;
        setup(v.x, v.y, v.stp, v.lat, v.rmode);
        pulse_start(t0);
        if (v.restart) begin
            bit seen = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk_sys);
                if (issue_idx >= 2) begin
                    seen = 1'b1;
                    break;
                end
            end
            check({nm, "_reached_dispatch"}, 32'(seen), 32'd1);
            start = 1'b1;
            @(negedge clk_sys);
            start = 1'b0;
        end
        wait_frame(nm);
        check({nm, "_first_start_latency"}, 32'(first_cs_cyc - t0), 32'd3);
        check({nm, "_pix5_re"}, 32'(cap_re5), 32'(v.re5));
        check({nm, "_pix5_im"}, 32'(cap_im5), 32'(v.im5));
        frame_checks(nm);
    endtask

    vec_t vecs [4];

    initial begin
        int t0;
        bit seen;
        int nwr_before, stray;
        logic [AW-1:0]  hold_a;
        logic [ITW-1:0] hold_d;

        //           x      y      step   lat rmode restart re5    im5
        vecs[0] = '{8'hF8, 8'hFC, 8'h02, 3,  0,    1'b0,   8'hFA, 8'hFE};
        vecs[1] = '{8'h7F, 8'h00, 8'h7F, 3,  0,    1'b0,   8'hFE, 8'h7F};
        vecs[2] = '{8'h00, 8'h00, 8'h01, 1,  1,    1'b0,   8'h01, 8'h01};
        vecs[3] = '{8'h0A, 8'hEC, 8'hFD, 5,  0,    1'b1,   8'h07, 8'hE9};

        repeat (3) @(negedge clk_sys);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_core_re", 32'(core_re), 32'd0);
        check("rst_core_im", 32'(core_im), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_data", 32'(fb_data), 32'd0);
        rst_sys = 1'b0;
        repeat (2) @(negedge clk_sys);

        for (int v = 0; v < 4; v++) run_frame(vecs[v], $sformatf("vec%0d", v));

        // Both cores finish together: core 0 is written first, core 1 the next cycle.
        setup(8'hF8, 8'hFC, 8'h02, 3, 0);
        auto_core = 1'b0;
        pulse_start(t0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_sys);
            if (issue_idx >= 2) begin seen = 1'b1; break; end
        end
        check("simul_both_issued", 32'(seen), 32'd1);
        repeat (2) @(negedge clk_sys);
        exp_data[0] = 8'd10;
        exp_data[1] = 8'd20;
        man_done  = 2'b11;
        man_iter  = {8'd20, 8'd10};
        auto_core = 1'b1;
        man_seq++;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_sys);
            if (nwr >= 2) begin seen = 1'b1; break; end
        end
        check("simul_two_writes", 32'(seen), 32'd1);
        check("simul_first_addr", 32'(wr_log_addr[0]), 32'd0);
        check("simul_second_addr", 32'(wr_log_addr[1]), 32'd1);
        check("simul_back_to_back", 32'(wr_log_cyc[1] - wr_log_cyc[0]), 32'd1);
        wait_frame("simul");
        frame_checks("simul");

        // Framebuffer stalls for 10 cycles with results pending.
        setup(8'hF8, 8'hFC, 8'h02, 3, 2);
        pulse_start(t0);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_sys);
            if (fb_we) begin seen = 1'b1; break; end
        end
        check("stall_we_seen", 32'(seen), 32'd1);
        hold_a = fb_addr;
        hold_d = fb_data;
        repeat (10) @(negedge clk_sys);
        check("stall_we_held", 32'(fb_we), 32'd1);
        check("stall_addr", 32'(fb_addr), 32'(hold_a));
        check("stall_data", 32'(fb_data), 32'(hold_d));
        check("stall_no_dispatch", 32'(issue_idx), 32'd2);
        check("stall_no_write", 32'(nwr), 32'd0);
        ready_mode = 0;
        wait_frame("stall");
        frame_checks("stall");

        // Reset mid-frame abandons it; in-flight core results must not be written.
        setup(8'hF8, 8'hFC, 8'h02, 3, 0);
        pulse_start(t0);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_sys);
            if (issue_idx >= 3) begin seen = 1'b1; break; end
        end
        check("rstmid_three_issued", 32'(seen), 32'd1);
        rst_sys = 1'b1;
        @(negedge clk_sys);
        rst_sys = 1'b0;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_fb_we", 32'(fb_we), 32'd0);
        check("rstmid_core_start", 32'(core_start), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        nwr_before = nwr;
        stray = 0;
        repeat (12) begin
            @(negedge clk_sys);
            if (fb_we || busy || core_start != '0) stray++;
        end
        check("rstmid_quiet", 32'(stray), 32'd0);
        check("rstmid_no_write", 32'(nwr), 32'(nwr_before));
        run_frame(vecs[0], "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
